// File: rtl/arbitro_rr_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the arbitro_rr round-robin merge arbiter.
//   N_PORTS : number of input class FIFOs
//   PORT_W  : width of a port index
//   CNT_W   : width of the per-grant pop counter (burst mode)
//   state_t : arbiter state (IDLE = no holder, HOLD = a port owns the grant)
//   port_onehot() : converts a port index to a one-hot pop vector
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_PORTS = 4;
    localparam int PORT_W  = 2;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] p);
        return N_PORTS'(1) << p;
    endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// -----------------------------------------------------------------------------
// arbitro_rr_if
// Bundles the input-FIFO side, the output-FIFO side and the status output of
// the round-robin merge arbiter.
//   fifo_empty      : empty flag of input FIFO i (bit i)
//   fifo_data       : head word of FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pop             : one-hot/zero pop strobe to the input FIFOs
//   out_almost_full : output FIFO has at most one free slot
//   push            : write strobe into the output FIFO
//   data_out        : word written into the output FIFO
//   grant_id        : index of the port that produced data_out
//   busy            : arbiter currently holds a grant
// Modports: master = arbiter side, slave = FIFO/environment side.
// -----------------------------------------------------------------------------
interface arbitro_rr_if #(
    parameter int DATA_WIDTH = 8
);
    import arb_pkg::*;

    logic [N_PORTS-1:0]            fifo_empty;
    logic [N_PORTS*DATA_WIDTH-1:0] fifo_data;
    logic [N_PORTS-1:0]            pop;
    logic                          out_almost_full;
    logic                          push;
    logic [DATA_WIDTH-1:0]         data_out;
    logic [PORT_W-1:0]             grant_id;
    logic                          busy;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  out_almost_full,
        output pop,
        output push,
        output data_out,
        output grant_id,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output out_almost_full,
        input  pop,
        input  push,
        input  data_out,
        input  grant_id,
        input  busy
    );

endinterface

// File: rtl/arbitro_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority search: returns the first requesting port
// in the order start, start+1, start+2, start+3 (mod N_PORTS).
//   req   : request vector (bit i = port i eligible)
//   start : port searched first
//   found : at least one port requests
//   idx   : winning port (equals start when nothing requests)
// -----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [PORT_W-1:0]  start,
    output logic               found,
    output logic [PORT_W-1:0]  idx
);

    // cand[k] is the port examined at search position k; the index wraps
    // naturally because it is PORT_W bits wide.
    logic [PORT_W-1:0]  cand [N_PORTS];
    logic [N_PORTS-1:0] cand_req;

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rot
        assign cand[gi]     = start + PORT_W'(gi);
        assign cand_req[gi] = req[cand[gi]];
    end

    // Scanned from the back so the earliest search position wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// -----------------------------------------------------------------------------
// arbitro_rr
// Round-robin arbiter draining four first-word-fall-through class FIFOs into
// one shared output FIFO. A popped word is pushed downstream one cycle later
// together with the index of its source port. All pops stall while the output
// FIFO reports almost-full.
//
// Optional feature macro: ARB_BURST_EN
//   defined   : a granted port keeps the grant for up to BURST_LEN words
//   undefined : strict per-word round-robin, no pop counter
//
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : arbitro_rr_if.master (FIFO flags/data in, pop/push/data/status out)
// Parameters:
//   DATA_WIDTH : FIFO word width
//   BURST_LEN  : max consecutive pops per grant in burst mode (1..15)
// -----------------------------------------------------------------------------
module arbitro_rr
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input logic         clk,
    input logic         reset,
    arbitro_rr_if.master bus
);

    state_t                  state_reg;
    logic [PORT_W-1:0]       rr_ptr_reg;
    logic [PORT_W-1:0]       cur_reg;
    logic                    push_reg;
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic [PORT_W-1:0]       grant_id_reg;
    logic                    busy_reg;

    logic [N_PORTS-1:0]      eligible;
    logic                    stall;
    logic [PORT_W-1:0]       cur_plus1;
    logic [PORT_W-1:0]       pick_start;
    logic                    pick_found;
    logic [PORT_W-1:0]       pick_idx;
    logic                    cont;
    logic                    pop_any;
    logic [PORT_W-1:0]       pop_idx;
    logic [DATA_WIDTH-1:0]   head [N_PORTS];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_head
        assign head[gi] = bus.fifo_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign eligible  = ~bus.fifo_empty;
    assign stall     = bus.out_almost_full;
    assign cur_plus1 = cur_reg + PORT_W'(1);

    // On release the search starts just after the releasing port, so that
    // port is examined last and only wins again when it is the sole requester.
    assign pick_start = (state_reg == HOLD) ? cur_plus1 : rr_ptr_reg;

    rr_pick u_pick (
        .req   (eligible),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ARB_BURST_EN
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    logic [CNT_W-1:0] cnt_reg;

    assign cont = (state_reg == HOLD) && eligible[cur_reg] && (cnt_reg < BURST_MAX);
`else
    // Every pop releases the grant; BURST_LEN has no effect in this build.
    assign cont = 1'b0;
    if (BURST_LEN < 1) begin : g_burst_len_ignored
    end
`endif

    // Holder continues, otherwise the rotating search result is used. Reset
    // and stall both force pop to zero.
    assign pop_idx = cont ? cur_reg : pick_idx;
    assign pop_any = !reset && !stall && (cont || pick_found);
    assign bus.pop = pop_any ? port_onehot(pop_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            cur_reg      <= '0;
            push_reg     <= 1'b0;
            data_out_reg <= '0;
            grant_id_reg <= '0;
            busy_reg     <= 1'b0;
`ifdef ARB_BURST_EN
            cnt_reg      <= '0;
`endif
        end else begin
            push_reg <= pop_any;
            if (pop_any) begin
                data_out_reg <= head[pop_idx];
                grant_id_reg <= pop_idx;
            end

            // Stall freezes the whole grant state.
            if (!stall) begin
                case (state_reg)
                    IDLE: begin
                        if (pick_found) begin
                            state_reg <= HOLD;
                            busy_reg  <= 1'b1;
                            cur_reg   <= pick_idx;
`ifdef ARB_BURST_EN
                            cnt_reg   <= CNT_W'(1);
`endif
                        end
                    end
                    HOLD: begin
                        if (cont) begin
`ifdef ARB_BURST_EN
                            cnt_reg <= cnt_reg + CNT_W'(1);
`endif
                        end else begin
                            rr_ptr_reg <= cur_plus1;
                            if (pick_found) begin
                                cur_reg <= pick_idx;
`ifdef ARB_BURST_EN
                                cnt_reg <= CNT_W'(1);
`endif
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.push     = push_reg;
    assign bus.data_out = data_out_reg;
    assign bus.grant_id = grant_id_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_arbitro_rr.sv
// -----------------------------------------------------------------------------
// tb_arbitro_rr
// Self-checking bench for arbitro_rr. Input FIFOs are modelled as queues; a
// behavioural arbiter model (holder / run length / next start port) predicts
// pop each cycle and the registered push/data_out/grant_id/busy after each
// edge. Directed phases follow the test plan, then a randomized phase.
// Build with +define+ARB_BURST_EN to exercise burst mode (BURST_LEN = 4).
// -----------------------------------------------------------------------------
module tb_arbitro_rr;

    localparam int DW = 8;
    localparam int BL = 4;
`ifdef ARB_BURST_EN
    localparam int RUN_LIMIT = BL;
`else
    localparam int RUN_LIMIT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arbitro_rr_if #(.DATA_WIDTH(DW)) bus ();

    arbitro_rr #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // input FIFO contents
    byte unsigned q [4][$];

    // reference model state
    bit m_hold;
    int m_cur, m_cnt, m_ptr;

    // expected registered outputs
    logic       exp_push;
    logic [7:0] exp_data;
    logic [1:0] exp_gid;
    logic       exp_busy;

    // recorded push sequence for directed checks
    bit          rec;
    int          gseq[$];
    byte unsigned dseq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check pop,
    // then advance the model across the rising edge.
    task automatic run_cycle(input logic rst, input logic almost_full);
        logic [3:0] m_pop;
        int s, w;
        bit found;
        @(negedge clk);
        check("push", bus.push, exp_push);
        check("data_out", bus.data_out, exp_data);
        check("grant_id", bus.grant_id, exp_gid);
        check("busy", bus.busy, exp_busy);
        if (exp_push)
            $display("[TB] t=%0t push port=%0d data=0x%02h", $time, exp_gid, exp_data);

        reset               = rst;
        bus.out_almost_full = almost_full;
        for (int i = 0; i < 4; i++) begin
            bus.fifo_empty[i] = (q[i].size() == 0);
            bus.fifo_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : 8'($urandom);
        end
        #1;

        m_pop = 4'b0;
        w     = 0;
        if (rst) begin
            m_hold = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
        end else if (!almost_full) begin
            if (m_hold && q[m_cur].size() != 0 && m_cnt < RUN_LIMIT) begin
                w = m_cur;
                m_pop[w] = 1'b1;
                m_cnt++;
            end else begin
                s = m_hold ? (m_cur + 1) % 4 : m_ptr;
                if (m_hold) m_ptr = s;
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && q[(s + k) % 4].size() != 0) begin
                        found = 1;
                        w = (s + k) % 4;
                    end
                end
                if (found) begin
                    m_pop[w] = 1'b1;
                    m_hold = 1; m_cur = w; m_cnt = 1;
                end else begin
                    m_hold = 0;
                end
            end
        end
        check("pop", bus.pop, m_pop);

        @(posedge clk);
        if (rst) begin
            exp_push = 1'b0; exp_data = 8'h00; exp_gid = 2'd0;
        end else if (m_pop != 4'b0) begin
            exp_push = 1'b1;
            exp_data = q[w].pop_front();
            exp_gid  = 2'(w);
            if (rec) begin
                gseq.push_back(w);
                dseq.push_back(exp_data);
            end
        end else begin
            exp_push = 1'b0;
        end
        exp_busy = m_hold;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (guard < 300 &&
               !(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 &&
                 q[3].size() == 0 && !exp_push && !exp_busy)) begin
            run_cycle(1'b0, 1'b0);
            guard++;
        end
        check("drain_in_time", 32'(guard < 300), 32'd1);
    endtask

    task automatic fill(input int port, input int n);
        for (int j = 0; j < n; j++) q[port].push_back(8'((port << 6) | (j + 1)));
    endtask

    int exp_seq [10];

    initial begin
        reset               = 1'b1;
        bus.fifo_empty      = 4'hF;
        bus.fifo_data       = '0;
        bus.out_almost_full = 1'b0;
        exp_push = 1'b0; exp_data = 8'h00; exp_gid = 2'd0; exp_busy = 1'b0;
        m_hold = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
        rec = 0;
        repeat (2) @(posedge clk);

        // reset state, then 10 idle cycles with every FIFO empty
        run_cycle(1'b1, 1'b0);
        repeat (10) run_cycle(1'b0, 1'b0);

        // single port 2 with three words
        q[2].push_back(8'h11); q[2].push_back(8'h22); q[2].push_back(8'h33);
        rec = 1; gseq.delete(); dseq.delete();
        drain();
        rec = 0;
        check("p2_count", gseq.size(), 3);
        for (int k = 0; k < 3 && k < gseq.size(); k++) begin
            check("p2_gid", gseq[k], 2);
            check("p2_data", dseq[k], 8'h11 * (k + 1));
        end

        // all four ports full: rotation order (per word or per burst)
        run_cycle(1'b1, 1'b0);
        for (int p = 0; p < 4; p++) fill(p, 8);
        rec = 1; gseq.delete(); dseq.delete();
        drain();
        rec = 0;
        check("full_count", gseq.size(), 32);
        for (int k = 0; k < 16 && k < gseq.size(); k++)
            check("full_order", gseq[k], (k / RUN_LIMIT) % 4);

        // port 1 holds only two words
        run_cycle(1'b1, 1'b0);
        fill(0, 8); fill(1, 2); fill(2, 8); fill(3, 8);
        rec = 1; gseq.delete(); dseq.delete();
        drain();
        rec = 0;
        if (RUN_LIMIT == 1) exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        else                exp_seq = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
        for (int k = 0; k < 10 && k < gseq.size(); k++)
            check("short_order", gseq[k], exp_seq[k]);

        // almost-full for 3 cycles after two pops of a run on port 0
        run_cycle(1'b1, 1'b0);
        fill(0, 8);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        repeat (3) run_cycle(1'b0, 1'b1);
        drain();

        // reset while port 3 holds the grant; next search starts at port 0
        fill(3, 5);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        fill(0, 2);
        rec = 1; gseq.delete(); dseq.delete();
        drain();
        rec = 0;
        check("post_reset_first", (gseq.size() != 0) ? gseq[0] : -1, 0);

        // randomized traffic, stalls and occasional reset
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 4; p++)
                if (q[p].size() < 6 && $urandom_range(0, 99) < 30)
                    q[p].push_back(8'($urandom));
            run_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
